// File: rtl/sc_check_pkg.sv
// rtl/sc_check_pkg.sv - shared state type and width helper for the scan-chain pulse checker
package sc_check_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FLUSH = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } sc_chk_state_t;

  // Width of a counter spanning 0..n-1, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sc_delay_line.sv
// rtl/sc_delay_line.sv - synchronous-clear shift register giving the expected scan-chain output
module sc_delay_line #(
  parameter int DEPTH = 80
) (
  input  logic clk,
  input  logic clear,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] line;

  always_ff @(posedge clk) begin
    if (clear) begin
      line <= '0;
    end else begin
      line <= {line[DEPTH-2:0], din};
    end
  end

  assign dout = line[DEPTH-1];

endmodule

// File: rtl/sc_chain_pulse_checker.sv
// rtl/sc_chain_pulse_checker.sv - drives pulses into the scan chain and checks them at the tail
module sc_chain_pulse_checker
  import sc_check_pkg::*;
#(
  parameter int CHAIN_LEN  = 80,
  parameter int PERIOD     = 20,
  parameter int NUM_PULSES = 4,
  parameter int ERR_W      = 16
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             start,
  output logic             sc_head,
  input  logic             sc_tail,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [15:0]      first_err_cyc
);

  localparam int LEN_W = clog2_min1(CHAIN_LEN);
  localparam int PH_W  = clog2_min1(PERIOD);
  localparam int PL_W  = clog2_min1(NUM_PULSES);

  sc_chk_state_t state, state_next;
  logic [LEN_W-1:0] len_cnt;
  logic [PH_W-1:0]  phase;
  logic [PL_W-1:0]  pulse_cnt;
  logic [15:0]      cmp_idx;
  logic             start_accept;
  logic             cmp_active;
  logic             expected;
  logic             len_last;
  logic             phase_last;

  assign start_accept = start && (state == IDLE || state == DONE);
  assign cmp_active   = (state == RUN) || (state == DRAIN);
  assign len_last     = (len_cnt == LEN_W'(CHAIN_LEN - 1));
  assign phase_last   = (phase == PH_W'(PERIOD - 1));

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start) state_next = FLUSH;
      FLUSH:      if (len_last) state_next = RUN;
      RUN:        if (phase_last && pulse_cnt == PL_W'(NUM_PULSES - 1)) state_next = DRAIN;
      DRAIN:      if (len_last) state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  // The delay line restarts with every run so stale pulses never reach the compare.
  sc_delay_line #(.DEPTH(CHAIN_LEN)) u_delay (
    .clk   (clk),
    .clear (Reset || start_accept),
    .din   (sc_head),
    .dout  (expected)
  );

  always_ff @(posedge clk) begin
    if (Reset) begin
      state         <= IDLE;
      len_cnt       <= '0;
      phase         <= '0;
      pulse_cnt     <= '0;
      sc_head       <= 1'b0;
      cmp_idx       <= '0;
      err_cnt       <= '0;
      first_err_cyc <= 16'hFFFF;
    end else begin
      state <= state_next;
      // Registered drive: raise it one edge early so the pulse lands on phase PERIOD-1.
      sc_head <= (state == RUN) && (phase == PH_W'(PERIOD - 2));

      if ((state == FLUSH || state == DRAIN) && state_next == state) begin
        len_cnt <= len_cnt + 1'b1;
      end else begin
        len_cnt <= '0;
      end

      if (state == RUN) begin
        phase <= phase_last ? '0 : phase + 1'b1;
        if (phase_last) pulse_cnt <= pulse_cnt + 1'b1;
      end else begin
        phase     <= '0;
        pulse_cnt <= '0;
      end

      if (start_accept) begin
        cmp_idx       <= '0;
        err_cnt       <= '0;
        first_err_cyc <= 16'hFFFF;
      end else if (cmp_active) begin
        cmp_idx <= cmp_idx + 16'd1;
        if (sc_tail != expected) begin
          if (err_cnt == '0) first_err_cyc <= cmp_idx;
          if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        end
      end
    end
  end

  assign busy = (state == FLUSH) || (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);
  assign pass = done && (err_cnt == '0);

endmodule

// File: tb/tb_sc_chain_pulse_checker.sv
// tb/tb_sc_chain_pulse_checker.sv - self-checking bench with a time-indexed run model
module tb_sc_chain_pulse_checker;

  localparam int CL  = 80;
  localparam int PER = 20;
  localparam int NP  = 4;
  localparam int RUN_LEN = 2 * CL + NP * PER;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0;
  logic        sc_head, sc_tail, busy, done, pass;
  logic [15:0] err_cnt, first_err_cyc;
  logic        s_head, s_busy, s_done, s_pass;
  logic [3:0]  s_err;
  logic [15:0] s_first;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  int chain_len = CL;
  int mode = 0;  // 0 shift chain, 1 stuck-at-0, 2 stuck-at-1
  logic [255:0] hist = '0;

  always #5 clk = ~clk;

  sc_chain_pulse_checker #(.CHAIN_LEN(CL), .PERIOD(PER), .NUM_PULSES(NP), .ERR_W(16)) dut (
    .clk(clk), .Reset(Reset), .start(start), .sc_head(sc_head), .sc_tail(sc_tail),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .first_err_cyc(first_err_cyc)
  );

  sc_chain_pulse_checker #(.CHAIN_LEN(CL), .PERIOD(PER), .NUM_PULSES(NP), .ERR_W(4)) dut_sat (
    .clk(clk), .Reset(Reset), .start(start), .sc_head(s_head), .sc_tail(1'b1),
    .busy(s_busy), .done(s_done), .pass(s_pass), .err_cnt(s_err), .first_err_cyc(s_first)
  );

  // Fabric scan chain of chain_len flops.
  always @(posedge clk) hist <= {hist[254:0], sc_head};
  assign sc_tail = (mode == 0) ? hist[chain_len-1] : (mode == 2);

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Run model: t counts cycles since the run began.
  bit m_run = 0, m_done = 0;
  int m_t = 0, m_err = 0, m_first = 16'hFFFF;

  function automatic bit head_at(input int t);
    return (t >= CL) && (t < CL + NP * PER) && (((t - CL) % PER) == PER - 1);
  endfunction

  always @(posedge clk) begin
    if (Reset) begin
      m_run = 0; m_done = 0; m_err = 0; m_first = 16'hFFFF;
    end else if (start && !m_run) begin
      m_run = 1; m_done = 0; m_t = 0; m_err = 0; m_first = 16'hFFFF;
    end else if (m_run) begin
      if (m_t >= CL && sc_tail != head_at(m_t - CL)) begin
        if (m_err == 0) m_first = (m_t - CL) & 16'hFFFF;
        if (m_err < 16'hFFFF) m_err++;
      end
      m_t++;
      if (m_t == RUN_LEN) begin
        m_run = 0; m_done = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, m_run);
      chk("done", done, m_done);
      chk("pass", pass, m_done && m_err == 0);
      chk("sc_head", sc_head, m_run && head_at(m_t));
      chk("err_cnt", err_cnt, m_err);
      chk("first_err_cyc", first_err_cyc, m_first);
    end
  end

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(output int nb);
    nb = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (done) break;
      if (busy) nb++;
    end
    if (done !== 1'b1) chk("wait_done_timeout", 0, 1);
  endtask

  int nb;

  initial begin
    repeat (3) @(posedge clk);
    #1 Reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_head", sc_head, 0);
    chk("rst_first", first_err_cyc, 16'hFFFF);

    // Matched chain.
    do_start(); wait_done(nb);
    chk("t1_busy_len", nb, 240);
    chk("t1_pass", pass, 1);
    chk("t1_err", err_cnt, 0);
    chk("t1_first", first_err_cyc, 16'hFFFF);
    chk("sat_err", s_err, 15);
    chk("sat_first", s_first, 0);
    chk("sat_done", s_done && !s_pass && !s_busy && !s_head, 1);

    // Chain one flop short: every pulse arrives a cycle early.
    chain_len = 79;
    do_start(); wait_done(nb);
    chk("t2_err", err_cnt, 8);
    chk("t2_pass", pass, 0);
    chk("t2_first", first_err_cyc, 98);
    chain_len = CL;

    mode = 1;
    do_start(); wait_done(nb);
    chk("t3_s0_err", err_cnt, 4);
    chk("t3_s0_first", first_err_cyc, 99);
    mode = 2;
    do_start(); wait_done(nb);
    chk("t3_s1_err", err_cnt, 156);
    chk("t3_s1_first", first_err_cyc, 0);

    // Abort at RUN cycle 30.
    do_start();
    repeat (111) @(negedge clk);
    chk("t4_err_before", err_cnt, 30);
    Reset = 1'b1;
    @(posedge clk); #1 Reset = 1'b0;
    @(negedge clk);
    chk("t4_busy", busy, 0);
    chk("t4_head", sc_head, 0);
    chk("t4_err", err_cnt, 0);
    mode = 0;
    do_start(); wait_done(nb);
    chk("t4_rerun_len", nb, 240);
    chk("t4_rerun_pass", pass, 1);

    // start while busy is ignored; start in DONE clears the result.
    mode = 1;
    do_start();
    repeat (111) @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(nb);
    chk("t5_len", nb + 111, 240);
    chk("t5_err", err_cnt, 4);
    mode = 0;
    do_start();
    @(negedge clk);
    chk("t5_restart_err", err_cnt, 0);
    chk("t5_restart_busy", busy, 1);
    wait_done(nb);
    chk("t5_restart_pass", pass, 1);

    // start and Reset together.
    @(negedge clk);
    start = 1'b1; Reset = 1'b1;
    @(posedge clk); #1 start = 1'b0; Reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t6_busy", busy, 0);
      chk("t6_done", done, 0);
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
